// File: rtl/ddr3_app_tester.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_app_tester
// Brief    : Writes a seeded pattern through a DDR3 controller app port,
//            reads it back and reports mismatches and read timeouts.
// Revision : 1.0
// ============================================================================
module ddr3_app_tester #(
    parameter int          C_ADDR_WIDTH = 28,
    parameter int          C_DATA_WIDTH = 64,
    parameter int          C_NUM_WORDS  = 16,
    parameter int          C_ADDR_STEP  = 8,
    parameter logic [31:0] C_SEED       = 32'hA5A5_0000,
    parameter int          C_TIMEOUT    = 4096
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    init_calib_complete,
    input  logic                    start,
    output logic [C_ADDR_WIDTH-1:0] app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [C_DATA_WIDTH-1:0] app_wdf_data,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    input  logic                    app_wdf_rdy,
    input  logic [C_DATA_WIDTH-1:0] app_rd_data,
    input  logic                    app_rd_data_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_cnt,
    output logic                    timeout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int unsigned             C_LANES    = C_DATA_WIDTH / 32;
    localparam logic [16:0]             C_N        = 17'(C_NUM_WORDS);
    localparam logic [C_ADDR_WIDTH-1:0] C_STEP     = C_ADDR_WIDTH'(C_ADDR_STEP);
    localparam int unsigned             C_TMO_W    = $clog2(C_TIMEOUT + 1);
    localparam logic [C_TMO_W-1:0]      C_TMO_LAST = C_TMO_W'(C_TIMEOUT - 1);
    localparam logic [2:0]              C_CMD_WR   = 3'b000;
    localparam logic [2:0]              C_CMD_RD   = 3'b001;

    function automatic logic [C_DATA_WIDTH-1:0] pattern(input logic [16:0] idx);
        logic [31:0] w;
        w = C_SEED + {15'd0, idx};
        return {C_LANES{w}};
    endfunction

    state_t                    state_q, state_d;
    logic [16:0]               cmd_idx_q, cmd_idx_d;
    logic [16:0]               wdf_idx_q, wdf_idx_d;
    logic [16:0]               rd_idx_q, rd_idx_d;
    logic [C_TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [15:0]               err_cnt_q, err_cnt_d;
    logic                      timeout_q, timeout_d;
    logic                      app_en_q, app_en_d;
    logic                      app_wdf_wren_q, app_wdf_wren_d;
    logic [C_ADDR_WIDTH-1:0]   app_addr_q, app_addr_d;
    logic [2:0]                app_cmd_q, app_cmd_d;
    logic [C_DATA_WIDTH-1:0]   app_wdf_data_q, app_wdf_data_d;

    logic cmd_hs, wdf_hs, rd_beat;

    assign cmd_hs  = app_en_q && app_rdy;
    assign wdf_hs  = app_wdf_wren_q && app_wdf_rdy;
    // Beats only count while a read pass is active and still expecting data
    assign rd_beat = app_rd_data_valid && (rd_idx_q < C_N) &&
                     ((state_q == ST_READ) || (state_q == ST_RD_WAIT));

    always_comb begin
        state_d        = state_q;
        cmd_idx_d      = cmd_idx_q;
        wdf_idx_d      = wdf_idx_q;
        rd_idx_d       = rd_idx_q;
        tmo_cnt_d      = tmo_cnt_q;
        err_cnt_d      = err_cnt_q;
        timeout_d      = timeout_q;
        app_en_d       = app_en_q;
        app_wdf_wren_d = app_wdf_wren_q;
        app_addr_d     = app_addr_q;
        app_cmd_d      = app_cmd_q;
        app_wdf_data_d = app_wdf_data_q;

        if (cmd_hs) begin
            cmd_idx_d  = cmd_idx_q + 17'd1;
            app_addr_d = app_addr_q + C_STEP;
            app_en_d   = (cmd_idx_q + 17'd1) < C_N;
        end
        if (wdf_hs) begin
            wdf_idx_d      = wdf_idx_q + 17'd1;
            app_wdf_data_d = pattern(wdf_idx_q + 17'd1);
            app_wdf_wren_d = (wdf_idx_q + 17'd1) < C_N;
        end
        if (rd_beat) begin
            rd_idx_d = rd_idx_q + 17'd1;
            if ((app_rd_data != pattern(rd_idx_q)) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && init_calib_complete) begin
                    state_d        = ST_WRITE;
                    cmd_idx_d      = 17'd0;
                    wdf_idx_d      = 17'd0;
                    rd_idx_d       = 17'd0;
                    tmo_cnt_d      = '0;
                    err_cnt_d      = 16'd0;
                    timeout_d      = 1'b0;
                    app_en_d       = 1'b1;
                    app_cmd_d      = C_CMD_WR;
                    app_addr_d     = '0;
                    app_wdf_wren_d = 1'b1;
                    app_wdf_data_d = pattern(17'd0);
                end
            end
            ST_WRITE: begin
                if ((cmd_idx_q == C_N) && (wdf_idx_q == C_N)) begin
                    state_d    = ST_READ;
                    cmd_idx_d  = 17'd0;
                    app_en_d   = 1'b1;
                    app_cmd_d  = C_CMD_RD;
                    app_addr_d = '0;
                end
            end
            ST_READ: begin
                if (cmd_idx_q == C_N) begin
                    state_d   = ST_RD_WAIT;
                    tmo_cnt_d = '0;
                end
            end
            ST_RD_WAIT: begin
                if (rd_idx_q == C_N) begin
                    state_d = ST_DONE;
                end else if (rd_beat) begin
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == C_TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q        <= ST_IDLE;
            cmd_idx_q      <= '0;
            wdf_idx_q      <= '0;
            rd_idx_q       <= '0;
            tmo_cnt_q      <= '0;
            err_cnt_q      <= '0;
            timeout_q      <= 1'b0;
            app_en_q       <= 1'b0;
            app_wdf_wren_q <= 1'b0;
            app_addr_q     <= '0;
            app_cmd_q      <= '0;
            app_wdf_data_q <= '0;
        end else begin
            state_q        <= state_d;
            cmd_idx_q      <= cmd_idx_d;
            wdf_idx_q      <= wdf_idx_d;
            rd_idx_q       <= rd_idx_d;
            tmo_cnt_q      <= tmo_cnt_d;
            err_cnt_q      <= err_cnt_d;
            timeout_q      <= timeout_d;
            app_en_q       <= app_en_d;
            app_wdf_wren_q <= app_wdf_wren_d;
            app_addr_q     <= app_addr_d;
            app_cmd_q      <= app_cmd_d;
            app_wdf_data_q <= app_wdf_data_d;
        end
    end

    assign app_addr     = app_addr_q;
    assign app_cmd      = app_cmd_q;
    assign app_en       = app_en_q;
    assign app_wdf_data = app_wdf_data_q;
    assign app_wdf_wren = app_wdf_wren_q;
    assign app_wdf_end  = app_wdf_wren_q;
    assign busy         = (state_q == ST_WRITE) || (state_q == ST_READ) ||
                          (state_q == ST_RD_WAIT);
    assign done         = (state_q == ST_DONE);
    assign pass         = done && (err_cnt_q == 16'd0) && !timeout_q;
    assign err_cnt      = err_cnt_q;
    assign timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_app_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_app_tester
// Brief    : Memory-model bench with write/read scoreboards and pass table.
// Revision : 1.0
// ============================================================================
module tb_ddr3_app_tester;

    localparam int          N    = 16;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_calib_complete = 1'b1;
    logic        start = 1'b0;
    logic [27:0] app_addr;
    logic [2:0]  app_cmd;
    logic        app_en;
    logic        app_rdy = 1'b0;
    logic [63:0] app_wdf_data;
    logic        app_wdf_wren;
    logic        app_wdf_end;
    logic        app_wdf_rdy = 1'b0;
    logic [63:0] app_rd_data = '0;
    logic        app_rd_data_valid = 1'b0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt;

    ddr3_app_tester dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .init_calib_complete(init_calib_complete), .start(start),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .timeout(timeout)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [27:0] addr;
        logic [63:0] data;
    } wr_t;
    typedef struct {
        int          due;
        logic [63:0] data;
    } rd_t;

    wr_t         exp_wr[$];
    logic [27:0] exp_rd[$];
    logic [27:0] wcmd_q[$];
    logic [63:0] wdat_q[$];
    rd_t         rd_pend[$];
    logic [63:0] mem [64];

    bit          bp_en = 1'b0;
    logic [31:0] corrupt_mask = '0;
    bit          drop_last = 1'b0;
    int          cyc = 0;
    int          rd_k = 0;

    function automatic logic [63:0] pat(input int i);
        logic [31:0] w;
        w = SEED + 32'(i);
        return {w, w};
    endfunction

    // Memory model: decides this cycle's handshakes after the DUT outputs settle
    task automatic model_step();
        rd_t         r;
        wr_t         e;
        logic [27:0] a;
        logic [63:0] d;
        cyc++;
        if (rd_pend.size() > 0 && rd_pend[0].due <= cyc) begin
            r = rd_pend.pop_front();
            app_rd_data       = r.data;
            app_rd_data_valid = 1'b1;
        end else begin
            app_rd_data       = '0;
            app_rd_data_valid = 1'b0;
        end
        app_rdy     = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        app_wdf_rdy = (wdat_q.size() >= 3) ? 1'b0 :
                      (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
        if (sys_rst_n && app_en && app_rdy) begin
            if (app_cmd == 3'b000) begin
                wcmd_q.push_back(app_addr);
            end else begin
                if (exp_rd.size() == 0) begin
                    check("rd_cmd_unexpected", 64'(app_addr), 64'hFFFF_FFFF);
                end else begin
                    a = exp_rd.pop_front();
                    check("rd_cmd_addr", 64'(app_addr), 64'(a));
                end
                d = mem[app_addr[8:3]];
                if (rd_k < 32 && corrupt_mask[rd_k]) d = d ^ 64'h1;
                if (!(drop_last && rd_k == N - 1)) rd_pend.push_back('{due: cyc + 20, data: d});
                rd_k++;
            end
        end
        if (sys_rst_n && app_wdf_wren && app_wdf_rdy) begin
            check("wdf_end", 64'(app_wdf_end), 64'd1);
            wdat_q.push_back(app_wdf_data);
        end
        while (wcmd_q.size() > 0 && wdat_q.size() > 0) begin
            a = wcmd_q.pop_front();
            d = wdat_q.pop_front();
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", d, 64'hDEAD);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 64'(a), 64'(e.addr));
                check("wr_data", d, e.data);
            end
            mem[a[8:3]] = d;
        end
    endtask

    initial forever begin
        @(negedge sys_clk);
        #1;
        model_step();
    end

    task automatic start_pass();
        rd_k = 0;
        foreach (mem[i]) mem[i] = '0;
        for (int i = 0; i < N; i++) begin
            exp_wr.push_back('{addr: 28'(i * 8), data: pat(i)});
            exp_rd.push_back(28'(i * 8));
        end
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        if (!done) check("done_wait_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_app_en"},   64'(app_en), 64'd0);
        check({tag, "_wren"},     64'(app_wdf_wren), 64'd0);
        check({tag, "_wdf_end"},  64'(app_wdf_end), 64'd0);
        check({tag, "_addr"},     64'(app_addr), 64'd0);
        check({tag, "_cmd"},      64'(app_cmd), 64'd0);
        check({tag, "_wdata"},    app_wdf_data, 64'd0);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_done"},     64'(done), 64'd0);
        check({tag, "_pass"},     64'(pass), 64'd0);
        check({tag, "_err_cnt"},  64'(err_cnt), 64'd0);
        check({tag, "_timeout"},  64'(timeout), 64'd0);
    endtask

    typedef struct {
        bit          bp;
        logic [31:0] cmask;
        bit          drop;
        logic [15:0] exp_err;
        bit          exp_pass;
        bit          exp_tmo;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{bp: 1'b0, cmask: 32'h0,  drop: 1'b0, exp_err: 16'd0, exp_pass: 1'b1, exp_tmo: 1'b0};
        vecs[1] = '{bp: 1'b1, cmask: 32'h0,  drop: 1'b0, exp_err: 16'd0, exp_pass: 1'b1, exp_tmo: 1'b0};
        vecs[2] = '{bp: 1'b0, cmask: 32'h88, drop: 1'b0, exp_err: 16'd2, exp_pass: 1'b0, exp_tmo: 1'b0};
        vecs[3] = '{bp: 1'b0, cmask: 32'h0,  drop: 1'b1, exp_err: 16'd0, exp_pass: 1'b0, exp_tmo: 1'b1};
        vecs[4] = '{bp: 1'b1, cmask: 32'h0,  drop: 1'b0, exp_err: 16'd0, exp_pass: 1'b1, exp_tmo: 1'b0};

        repeat (3) @(negedge sys_clk);
        check_reset_outputs("por");
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int v = 0; v < 5; v++) begin
            bp_en        = vecs[v].bp;
            corrupt_mask = vecs[v].cmask;
            drop_last    = vecs[v].drop;
            start_pass();
            check($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
            wait_done();
            check($sformatf("v%0d_done", v),    64'(done), 64'd1);
            check($sformatf("v%0d_pass", v),    64'(pass), 64'(vecs[v].exp_pass));
            check($sformatf("v%0d_err_cnt", v), 64'(err_cnt), 64'(vecs[v].exp_err));
            check($sformatf("v%0d_timeout", v), 64'(timeout), 64'(vecs[v].exp_tmo));
            check($sformatf("v%0d_wr_left", v), 64'(exp_wr.size()), 64'd0);
            check($sformatf("v%0d_rd_left", v), 64'(exp_rd.size()), 64'd0);
            if (vecs[v].bp) check($sformatf("v%0d_mem5", v), mem[5], 64'hA5A5_0005_A5A5_0005);
        end
        bp_en = 1'b0; corrupt_mask = '0; drop_last = 1'b0;

        // start while busy is ignored; calibration loss mid-pass does not abort
        start_pass();
        repeat (4) @(negedge sys_clk);
        pulse_start();
        check("busy_restart_busy", 64'(busy), 64'd1);
        init_calib_complete = 1'b0;
        wait_done();
        check("busy_restart_pass", 64'(pass), 64'd1);
        check("busy_restart_wr_left", 64'(exp_wr.size()), 64'd0);
        pulse_start();
        repeat (3) @(negedge sys_clk);
        check("nocalib_done", 64'(done), 64'd1);
        check("nocalib_busy", 64'(busy), 64'd0);
        init_calib_complete = 1'b1;

        // rerun from DONE after a failing pass clears err_cnt
        corrupt_mask = 32'h88;
        start_pass();
        wait_done();
        check("rerun_err_first", 64'(err_cnt), 64'd2);
        corrupt_mask = '0;
        start_pass();
        check("rerun_err_cleared", 64'(err_cnt), 64'd0);
        wait_done();
        check("rerun_pass", 64'(pass), 64'd1);

        // reset during READ, with stale read beats landing in IDLE
        start_pass();
        n = 0;
        while (!(app_en && app_cmd == 3'b001) && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        check("reach_read", 64'(app_en && app_cmd == 3'b001), 64'd1);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check_reset_outputs("midrst");
        sys_rst_n = 1'b1;
        exp_wr.delete(); exp_rd.delete(); wcmd_q.delete(); wdat_q.delete();
        repeat (40) @(negedge sys_clk);
        check("stale_err_cnt", 64'(err_cnt), 64'd0);
        check("stale_busy", 64'(busy), 64'd0);
        check("stale_done", 64'(done), 64'd0);
        start_pass();
        wait_done();
        check("post_rst_pass", 64'(pass), 64'd1);
        check("post_rst_err", 64'(err_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr3_app_tester.md
DDR3_APP_TESTER -- requirements
Module: ddr3_app_tester

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 28, width of the app address.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 64, app data width, a multiple of 32.
REQ-003 SHALL have parameter C_NUM_WORDS, default 16, number of words per pass, range 1..65535.
REQ-004 SHALL have parameter C_ADDR_STEP, default 8, address increment per word.
REQ-005 SHALL have parameter C_SEED, default 32'hA5A5_0000, base value of the data pattern.
REQ-006 SHALL have parameter C_TIMEOUT, default 4096, maximum idle cycles while waiting for read data.
REQ-007 SHALL provide the following ports:
  - sys_clk  in  1  single clock, also the controller user-interface clock.
  - sys_rst_n  in  1  synchronous active-low reset.
  - init_calib_complete  in  1  controller calibration done.
  - start  in  1  pulse that begins a write/read pass.
  - app_addr  out  C_ADDR_WIDTH  command address.
  - app_cmd  out  3  3'b000 write, 3'b001 read.
  - app_en  out  1  command valid.
  - app_rdy  in  1  command accepted when app_en and app_rdy are both high.
  - app_wdf_data  out  C_DATA_WIDTH  write data.
  - app_wdf_wren  out  1  write data valid.
  - app_wdf_end  out  1  equals app_wdf_wren (one beat per word).
  - app_wdf_rdy  in  1  write data accepted when app_wdf_wren and app_wdf_rdy are both high.
  - app_rd_data  in  C_DATA_WIDTH  read data.
  - app_rd_data_valid  in  1  read data strobe.
  - busy  out  1  pass in progress.
  - done  out  1  pass finished; held until the next start.
  - pass  out  1  valid while done is high; 1 means no errors and no timeout.
  - err_cnt  out  16  count of mismatching read words, saturating.
  - timeout  out  1  read wait exceeded C_TIMEOUT.

Function
REQ-008 SHALL implement the states IDLE, WRITE, READ, RD_WAIT and DONE.
REQ-009 In IDLE and DONE, start SHALL be honoured only when init_calib_complete=1; on acceptance the block SHALL clear err_cnt and timeout, drop done and pass, and enter WRITE on the next cycle.
REQ-010 Pattern: word i (0..C_NUM_WORDS-1) SHALL be the 32-bit value (C_SEED+i) mod 2^32 replicated across C_DATA_WIDTH/32 lanes.
REQ-011 Address: word i SHALL use address i*C_ADDR_STEP, truncated to C_ADDR_WIDTH bits (wraps).
REQ-012 WRITE: command and data SHALL be tracked by independent counters (cmd_idx, wdf_idx).
  - app_en SHALL be high while cmd_idx<C_NUM_WORDS.
  - app_wdf_wren SHALL be high while wdf_idx<C_NUM_WORDS.
  - Each counter SHALL advance only on its own handshake.
  - Data may lead or lag its command by any number of words.
REQ-013 WRITE SHALL exit to READ the cycle after both counters reach C_NUM_WORDS.
REQ-014 READ: app_cmd SHALL be 3'b001, app_en SHALL stay high until C_NUM_WORDS commands are accepted, and the block SHALL then enter RD_WAIT.
REQ-015 Read data SHALL be compared in order during both READ and RD_WAIT.
  - The k-th valid beat SHALL be compared against pattern word k.
  - Each mismatch SHALL increment err_cnt, saturating at 16'hFFFF.
  - Beats beyond C_NUM_WORDS SHALL be ignored.
REQ-016 RD_WAIT SHALL go to DONE when C_NUM_WORDS beats have been received.
REQ-017 The timeout counter SHALL reset on every app_rd_data_valid beat.
  - If C_TIMEOUT consecutive cycles pass without a beat while beats are still outstanding, the block SHALL set timeout=1 and go to DONE.
REQ-018 In DONE, done SHALL be 1 and pass SHALL be (err_cnt==0 && !timeout).
REQ-019 busy SHALL be 1 exactly in WRITE, READ and RD_WAIT.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 init_calib_complete falling mid-pass SHALL NOT abort the pass.
REQ-022 app_en and app_wdf_wren SHALL be registered outputs, and app_addr, app_cmd and app_wdf_data SHALL remain stable while their valid is high and not yet accepted.

Reset
REQ-023 While sys_rst_n=0 at a sys_clk edge, the block SHALL enter IDLE and drive app_en=0, app_wdf_wren=0, app_wdf_end=0, app_addr=0, app_cmd=0, app_wdf_data=0, busy=0, done=0, pass=0, err_cnt=0 and timeout=0.
REQ-024 A reset asserted mid-pass SHALL abandon the pass immediately, and read beats arriving after reset release SHALL be ignored while in IDLE.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - Ideal memory model (app_rdy=app_wdf_rdy=1, read latency 20), C_NUM_WORDS=16, one start: 16 writes, then 16 reads; done=1, pass=1, err_cnt=0.
  - Random app_rdy/app_wdf_rdy backpressure (~50%) with data accepted up to 3 words ahead of commands: memory contents equal the pattern (word 5 = 32'hA5A5_0005 per lane); pass=1.
  - Model corrupts read words 3 and 7: err_cnt=2, pass=0, timeout=0.
  - Model drops the last read beat: timeout=1 after 4096 idle cycles; done=1, pass=0.
  - start pulsed while busy, and start with init_calib_complete=0: both ignored; a second start from DONE reruns and clears err_cnt.
  - sys_rst_n pulled low during READ: next cycle all outputs are at reset values; a subsequent start completes with pass=1.
